dev_bridge: RTL and testbench
=============================

DEV_BRIDGE -- requirements
Module: dev_bridge

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 16, number of WAIT cycles without ack before a timeout error; legal range 2..255.
REQ-002 Clocking: one clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 reset_n  in  1  asynchronous active-low reset.
REQ-005 cpu_req  in  1  request strobe, sampled only in IDLE.
REQ-006 cpu_we  in  1  1 = write, 0 = read.
REQ-007 cpu_addr  in  32  byte address; bits [5:4] select the device, bits [3:0] are the device offset.
REQ-008 cpu_wdata  in  32  write data.
REQ-009 cpu_busy  out  1  high while a transaction is outstanding (WAIT, DONE).
REQ-010 cpu_done  out  1  one-cycle completion pulse.
REQ-011 cpu_rdata  out  32  read data, valid when cpu_done=1.
REQ-012 cpu_err  out  1  error flag, valid when cpu_done=1.
REQ-013 dev_sel  out  4  one-hot device select; all zero when idle.
REQ-014 dev_we, dev_addr[3:0], dev_wdata[31:0]  out  latched copies of cpu_we, cpu_addr[3:0] and cpu_wdata.
REQ-015 dev_ack  in  4  per-device acknowledge.
REQ-016 dev_rdata0..dev_rdata3  in  32 each  per-device read data.

Function
REQ-017 FSM states SHALL be IDLE, WAIT and DONE, encoded as 2 bits.
REQ-018 In IDLE with cpu_req=1 and cpu_addr[31:6]==0, the block SHALL latch we, addr and wdata, set dev_sel to the one-hot decode of addr[5:4], and enter WAIT.
REQ-019 In IDLE with cpu_req=1 and cpu_addr[31:6]!=0, the block SHALL keep dev_sel at 0, set the error flag, set rdata to 0, and enter DONE.
REQ-020 dev_sel, dev_we, dev_addr and dev_wdata SHALL be registered and held stable for the whole of WAIT.
REQ-021 In WAIT, dev_ack on the selected bit SHALL capture the selected dev_rdataN into cpu_rdata (reads only; writes load 0), clear the error flag, deassert dev_sel, and enter DONE.
REQ-022 dev_ack bits of unselected devices SHALL be ignored.
REQ-023 In DONE, cpu_done=1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-024 cpu_rdata and cpu_err SHALL hold their values until the next transaction completes.
REQ-025 cpu_req SHALL be ignored in WAIT and DONE; a new request is first accepted in the IDLE cycle after DONE.
REQ-026 Minimum latency: request sampled at edge N, ack present in the first WAIT cycle, cpu_done high in the cycle after edge N+1.
REQ-027 cpu_busy SHALL be a combinational decode of state (WAIT or DONE).

Reset
REQ-028 Asserting reset_n low SHALL force IDLE immediately, regardless of state, including mid-WAIT.
REQ-029 During reset, dev_sel=0, dev_we=0, dev_addr=0, dev_wdata=0, cpu_done=0, cpu_err=0, cpu_rdata=0 and the timeout counter=0.
REQ-030 A transaction aborted by reset SHALL produce no cpu_done.

Configuration
REQ-031 Macro DEV_BRIDGE_TIMEOUT_EN:
- Defined: an 8-bit counter clears on entry to WAIT and increments each WAIT cycle. When it reaches TIMEOUT_CYCLES-1 with no selected ack, the block enters DONE with cpu_err=1 and cpu_rdata=0. An ack in the same cycle as the timeout wins (no error).
- Not defined: no counter is built, and WAIT persists until ack or reset.

Verification
REQ-032 Read dev2: cpu_addr=0x24, dev_ack[2] in the first WAIT cycle, dev_rdata2=0xDEADBEEF -> dev_sel=4'b0100, cpu_done two cycles after the request, cpu_rdata=0xDEADBEEF, cpu_err=0.
REQ-033 Write dev0: cpu_addr=0x08, cpu_wdata=0x12345678, ack after 3 WAIT cycles -> dev_we=1, dev_addr=4'h8, dev_wdata stable throughout WAIT, single cpu_done pulse.
REQ-034 Out-of-range request: cpu_addr=0x40 -> dev_sel stays 0, cpu_done the next cycle with cpu_err=1 and cpu_rdata=0.
REQ-035 Timeout (macro defined, TIMEOUT_CYCLES=16), no ack -> cpu_done after 16 WAIT cycles with cpu_err=1; ack on cycle 16 -> cpu_err=0.
REQ-036 Stray ack and request: dev_ack[1] while dev3 is selected -> no completion. cpu_req during WAIT -> ignored. Reset_n low mid-WAIT -> IDLE with all outputs 0 and no cpu_done.

Source files
------------

// File: rtl/dev_bridge.sv
// ============================================================================
// Module   : dev_bridge
// Purpose  : CPU-to-device request bridge. Decodes cpu_addr[5:4] into a
//            one-hot select across four devices, waits for the selected
//            device's ack, and returns read data plus an error flag to the CPU.
//            Optional WAIT timeout is enabled with `define DEV_BRIDGE_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dev_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_busy,
    output logic        cpu_done,
    output logic [31:0] cpu_rdata,
    output logic        cpu_err,
    output logic [3:0]  dev_sel,
    output logic        dev_we,
    output logic [3:0]  dev_addr,
    output logic [31:0] dev_wdata,
    input  logic [3:0]  dev_ack,
    input  logic [31:0] dev_rdata0,
    input  logic [31:0] dev_rdata1,
    input  logic [31:0] dev_rdata2,
    input  logic [31:0] dev_rdata3
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    generate
        if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_param_check
            $error("dev_bridge: TIMEOUT_CYCLES must be in 2..255");
        end
    endgenerate

    state_t      state_q, state_d;
    logic [3:0]  dev_sel_q, dev_sel_d;
    logic        dev_we_q, dev_we_d;
    logic [3:0]  dev_addr_q, dev_addr_d;
    logic [31:0] dev_wdata_q, dev_wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        w_ack_hit;
    logic [31:0] w_sel_rdata;

`ifdef DEV_BRIDGE_TIMEOUT_EN
    localparam logic [7:0] c_tmo_last = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] tmo_cnt_q, tmo_cnt_d;
`endif

    // dev_sel_q is one-hot during WAIT, so an AND-OR mux picks the live device.
    assign w_ack_hit   = |(dev_ack & dev_sel_q);
    assign w_sel_rdata = ({32{dev_sel_q[0]}} & dev_rdata0)
                       | ({32{dev_sel_q[1]}} & dev_rdata1)
                       | ({32{dev_sel_q[2]}} & dev_rdata2)
                       | ({32{dev_sel_q[3]}} & dev_rdata3);

    always_comb begin
        state_d     = state_q;
        dev_sel_d   = dev_sel_q;
        dev_we_d    = dev_we_q;
        dev_addr_d  = dev_addr_q;
        dev_wdata_d = dev_wdata_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
`ifdef DEV_BRIDGE_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (cpu_req) begin
                    if (cpu_addr[31:6] == 26'd0) begin
                        dev_we_d    = cpu_we;
                        dev_addr_d  = cpu_addr[3:0];
                        dev_wdata_d = cpu_wdata;
                        dev_sel_d   = 4'b0001 << cpu_addr[5:4];
`ifdef DEV_BRIDGE_TIMEOUT_EN
                        tmo_cnt_d   = 8'd0;
`endif
                        state_d     = ST_WAIT;
                    end else begin
                        err_d   = 1'b1;
                        rdata_d = 32'd0;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_WAIT: begin
                if (w_ack_hit) begin
                    rdata_d   = dev_we_q ? 32'd0 : w_sel_rdata;
                    err_d     = 1'b0;
                    dev_sel_d = 4'd0;
                    state_d   = ST_DONE;
                end
`ifdef DEV_BRIDGE_TIMEOUT_EN
                else if (tmo_cnt_q == c_tmo_last) begin
                    rdata_d   = 32'd0;
                    err_d     = 1'b1;
                    dev_sel_d = 4'd0;
                    state_d   = ST_DONE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
                end
`endif
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            dev_sel_q   <= 4'd0;
            dev_we_q    <= 1'b0;
            dev_addr_q  <= 4'd0;
            dev_wdata_q <= 32'd0;
            rdata_q     <= 32'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            dev_sel_q   <= dev_sel_d;
            dev_we_q    <= dev_we_d;
            dev_addr_q  <= dev_addr_d;
            dev_wdata_q <= dev_wdata_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

`ifdef DEV_BRIDGE_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt_q <= 8'd0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`endif

    assign cpu_busy  = (state_q == ST_WAIT) || (state_q == ST_DONE);
    assign cpu_done  = (state_q == ST_DONE);
    assign cpu_rdata = rdata_q;
    assign cpu_err   = err_q;
    assign dev_sel   = dev_sel_q;
    assign dev_we    = dev_we_q;
    assign dev_addr  = dev_addr_q;
    assign dev_wdata = dev_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_dev_bridge.sv
// ============================================================================
// Module   : tb_dev_bridge
// Purpose  : Self-checking bench for dev_bridge: directed scenarios plus
//            randomized traffic against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dev_bridge;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [31:0] cpu_addr = 32'd0;
    logic [31:0] cpu_wdata = 32'd0;
    logic        cpu_busy, cpu_done, cpu_err, dev_we;
    logic [31:0] cpu_rdata, dev_wdata;
    logic [3:0]  dev_sel, dev_addr;
    logic [3:0]  dev_ack = 4'd0;
    logic [31:0] rd [4] = '{32'd0, 32'd0, 32'd0, 32'd0};

    int n_checks = 0;
    int n_fail = 0;

    dev_bridge #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_busy(cpu_busy), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
        .dev_sel(dev_sel), .dev_we(dev_we), .dev_addr(dev_addr), .dev_wdata(dev_wdata),
        .dev_ack(dev_ack),
        .dev_rdata0(rd[0]), .dev_rdata1(rd[1]), .dev_rdata2(rd[2]), .dev_rdata3(rd[3])
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level reference: one request in flight, one done cycle after it.
    bit          m_inflight = 1'b0;
    bit          m_done = 1'b0;
    bit          m_we = 1'b0;
    bit          m_err = 1'b0;
    int          m_idx = 0;
    int          m_waits = 0;
    logic [3:0]  m_addr = 4'd0;
    logic [31:0] m_wdata = 32'd0;
    logic [31:0] m_rdata = 32'd0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_inflight <= 1'b0; m_done <= 1'b0; m_we <= 1'b0; m_err <= 1'b0;
            m_idx <= 0; m_waits <= 0; m_addr <= 4'd0; m_wdata <= 32'd0; m_rdata <= 32'd0;
        end else if (m_done) begin
            m_done <= 1'b0;
        end else if (m_inflight) begin
            m_waits <= m_waits + 1;
            if (dev_ack[m_idx]) begin
                m_rdata    <= m_we ? 32'd0 : rd[m_idx];
                m_err      <= 1'b0;
                m_inflight <= 1'b0;
                m_done     <= 1'b1;
            end
`ifdef DEV_BRIDGE_TIMEOUT_EN
            else if (m_waits + 1 == TMO) begin
                m_rdata    <= 32'd0;
                m_err      <= 1'b1;
                m_inflight <= 1'b0;
                m_done     <= 1'b1;
            end
`endif
        end else if (cpu_req) begin
            if (cpu_addr[31:6] == 26'd0) begin
                m_we       <= cpu_we;
                m_addr     <= cpu_addr[3:0];
                m_wdata    <= cpu_wdata;
                m_idx      <= int'(cpu_addr[5:4]);
                m_waits    <= 0;
                m_inflight <= 1'b1;
            end else begin
                m_err   <= 1'b1;
                m_rdata <= 32'd0;
                m_done  <= 1'b1;
            end
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        chk("busy",  32'(cpu_busy),  32'(m_inflight | m_done));
        chk("done",  32'(cpu_done),  32'(m_done));
        chk("rdata", cpu_rdata,      m_rdata);
        chk("err",   32'(cpu_err),   32'(m_err));
        chk("sel",   32'(dev_sel),   m_inflight ? (32'd1 << m_idx) : 32'd0);
        chk("we",    32'(dev_we),    32'(m_we));
        chk("addr",  32'(dev_addr),  32'(m_addr));
        chk("wdata", dev_wdata,      m_wdata);
    end

    bit hang = 1'b0;

    initial begin
        #1 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_sel",   32'(dev_sel), 32'd0);
        chk("rst_rdata", cpu_rdata,    32'd0);
        chk("rst_busy",  32'(cpu_busy), 32'd0);
        #3 reset_n = 1'b1;

        // Read dev2, ack in first WAIT cycle
        @(negedge clk); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h24; rd[2] = 32'hDEADBEEF;
        @(negedge clk); cpu_req = 1'b0;
        chk("rd2_sel",  32'(dev_sel),  32'b0100);
        chk("rd2_busy", 32'(cpu_busy), 32'd1);
        dev_ack = 4'b0100;
        @(negedge clk); dev_ack = 4'd0;
        chk("rd2_done",  32'(cpu_done), 32'd1);
        chk("rd2_rdata", cpu_rdata,     32'hDEADBEEF);
        chk("rd2_model", m_rdata,       32'hDEADBEEF);
        chk("rd2_err",   32'(cpu_err),  32'd0);
        chk("rd2_seloff", 32'(dev_sel), 32'd0);
        @(negedge clk);
        chk("rd2_once", 32'(cpu_done), 32'd0);
        chk("rd2_hold", cpu_rdata,      32'hDEADBEEF);

        // Write dev0, ack in the fourth WAIT cycle
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h08; cpu_wdata = 32'h12345678;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 1) begin cpu_req = 1'b0; cpu_wdata = 32'hA5A5A5A5; end
            chk("wr0_we",    32'(dev_we),   32'd1);
            chk("wr0_addr",  32'(dev_addr), 32'h8);
            chk("wr0_wdata", dev_wdata,     32'h12345678);
            chk("wr0_sel",   32'(dev_sel),  32'b0001);
            chk("wr0_nodone", 32'(cpu_done), 32'd0);
            if (k == 4) dev_ack = 4'b0001;
        end
        @(negedge clk); dev_ack = 4'd0;
        chk("wr0_done",  32'(cpu_done), 32'd1);
        chk("wr0_rdata", cpu_rdata,     32'd0);
        @(negedge clk);
        chk("wr0_once", 32'(cpu_done), 32'd0);

        // Out-of-range request
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
        @(negedge clk); cpu_req = 1'b0;
        chk("oor_done",  32'(cpu_done), 32'd1);
        chk("oor_err",   32'(cpu_err),  32'd1);
        chk("oor_rdata", cpu_rdata,     32'd0);
        chk("oor_sel",   32'(dev_sel),  32'd0);
        chk("oor_model", 32'(m_err),    32'd1);
        @(negedge clk);
        chk("oor_once", 32'(cpu_done), 32'd0);
        chk("oor_hold", 32'(cpu_err),  32'd1);

        // Stray ack on dev1 while dev3 selected; request during WAIT ignored
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h30;
        @(negedge clk); cpu_addr = 32'h04; cpu_we = 1'b1; dev_ack = 4'b0010;
        repeat (3) begin
            @(negedge clk);
            chk("stray_nodone", 32'(cpu_done), 32'd0);
            chk("stray_busy",   32'(cpu_busy), 32'd1);
            chk("stray_sel",    32'(dev_sel),  32'b1000);
            chk("stray_addr",   32'(dev_addr), 32'h0);
        end
        // Reset mid-WAIT
        #2 reset_n = 1'b0; cpu_req = 1'b0; dev_ack = 4'd0;
        #1;
        chk("abort_busy", 32'(cpu_busy), 32'd0);
        chk("abort_sel",  32'(dev_sel),  32'd0);
        chk("abort_err",  32'(cpu_err),  32'd0);
        @(negedge clk); #2 reset_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("abort_nodone", 32'(cpu_done), 32'd0);
        end

`ifdef DEV_BRIDGE_TIMEOUT_EN
        // Timeout with no ack, then ack on the last WAIT cycle
        for (int pass = 0; pass < 2; pass++) begin
            @(negedge clk); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10; rd[1] = 32'hCAFE0001;
            for (int k = 1; k <= TMO; k++) begin
                @(negedge clk); cpu_req = 1'b0;
                chk("tmo_wait", 32'(cpu_done), 32'd0);
                if (pass == 1 && k == TMO) dev_ack = 4'b0010;
            end
            @(negedge clk); dev_ack = 4'd0;
            chk("tmo_done",  32'(cpu_done), 32'd1);
            chk("tmo_err",   32'(cpu_err),  (pass == 0) ? 32'd1 : 32'd0);
            chk("tmo_rdata", cpu_rdata,     (pass == 0) ? 32'd0 : 32'hCAFE0001);
        end
`endif

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if ($urandom_range(499) == 0) begin
                #2 reset_n = 1'b0;
                @(negedge clk);
                #2 reset_n = 1'b1;
                @(negedge clk);
            end
            cpu_req   = ($urandom_range(2) == 0);
            cpu_we    = $urandom_range(1) == 1;
            cpu_addr  = ($urandom_range(7) == 0) ? $urandom : {26'd0, 6'($urandom)};
            cpu_wdata = $urandom;
            for (int i = 0; i < 4; i++) rd[i] = $urandom;
            dev_ack = 4'($urandom);
            if (m_inflight) begin
                if (m_waits == 0) hang = ($urandom_range(3) == 0);
                dev_ack[m_idx] = 1'b0;
`ifdef DEV_BRIDGE_TIMEOUT_EN
                if (!hang && $urandom_range(2) == 0) dev_ack[m_idx] = 1'b1;
`else
                if ((!hang && $urandom_range(2) == 0) || m_waits >= 20) dev_ack[m_idx] = 1'b1;
`endif
            end
        end

        cpu_req = 1'b0; dev_ack = 4'd0;
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
